regwr_arbiter: RTL and testbench
================================

REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter pw, default 4: register address width, 2**pw registers.
REQ-002 Parameter NREQ, default 3: number of write requesters, legal range 2..8.
REQ-003 Clk  input  1: single clock; all state on posedge Clk.
REQ-004 Reset  input  1: reset, asynchronous, active-high.
REQ-005 Req  input  NREQ: per-requester write request, level-held until granted.
REQ-006 ReqAddr  input  NREQ x pw: per-requester destination register.
REQ-007 ReqData  input  NREQ x 8: per-requester write data.
REQ-008 Gnt  output  NREQ: one-hot grant, combinational, at most one bit high per cycle.
REQ-009 WriteEn  output  1: register-file write enable, registered.
REQ-010 Waddr  output  pw: register-file write address, registered.
REQ-011 DataIn  output  8: register-file write data, registered.
REQ-012 Ready  output  1: high when clear sequence is done and arbitration is active.

Function
REQ-013 FSM states: CLEAR, ARB; the block SHALL enter CLEAR on reset.
REQ-014 In CLEAR: clear counter cnt starts at 0; each edge registers WriteEn=1, Waddr=cnt, DataIn=0; cnt increments.
REQ-015 At the edge that registers Waddr=2**pw-1, the FSM SHALL go to ARB; the clear sequence takes exactly 2**pw edges.
REQ-016 In CLEAR: Gnt=0 and Ready=0 regardless of Req.
REQ-017 In ARB: Ready=1.
REQ-018 In ARB: winner = first asserted Req index at or after rr_ptr, searching upward modulo NREQ.
REQ-019 In ARB, winner grant: Gnt[winner]=1 in the same cycle.
REQ-020 In ARB, write issue: next edge registers WriteEn=1, Waddr=ReqAddr[winner], DataIn=ReqData[winner]; latency is 1 cycle from grant to write.
REQ-021 In ARB, pointer update: rr_ptr <= (winner+1) mod NREQ.
REQ-022 In ARB with no Req: Gnt=0, next edge registers WriteEn=0, rr_ptr unchanged, and Waddr/DataIn hold their values.
REQ-023 A granted requester SHALL see Gnt for one cycle only; if its Req stays high the next cycle, that is a new request.
REQ-024 Simultaneous requests to the same ReqAddr: one write per cycle, in round-robin order; the later grant's data lands last.
REQ-025 Throughput: one write per cycle sustained; with all NREQ requesting, each requester is granted once every NREQ cycles.
REQ-026 Wrap-around: rr_ptr = NREQ-1 followed by a grant to NREQ-1 SHALL give rr_ptr=0.

Reset
REQ-027 Reset asserted SHALL immediately set: state=CLEAR, cnt=0, rr_ptr=0, WriteEn=0, Waddr=0, DataIn=0, Gnt=0, Ready=0.
REQ-028 Reset mid-operation SHALL discard any in-flight write and restart the full clear sequence after Reset deasserts.
REQ-029 First clear write SHALL occur at the first posedge Clk after Reset deasserts.

Configuration
REQ-030 Macro REGWR_ARBITER_STATS_EN, when defined, SHALL add two outputs:
  - WrCount (16 bits): arbitrated writes, excluding clear writes.
  - ConflictCount (16 bits): ARB cycles with two or more Req bits high.
REQ-031 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-032 Without the macro, these ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-033 Clear sequence: release Reset, Req=0 -> WriteEn=1 on 16 consecutive edges, Waddr 0..15, DataIn=0; then Ready=1 and WriteEn=0.
REQ-034 Single requester: Req=3'b010, ReqAddr[1]=4'h7, ReqData[1]=8'hA5 in ARB -> Gnt=3'b010 that cycle; next edge WriteEn=1, Waddr=7, DataIn=A5; rr_ptr=2.
REQ-035 Round-robin: Req=3'b111 held for 6 cycles from rr_ptr=0 -> grant order 0,1,2,0,1,2; WriteEn high all 6 following edges.
REQ-036 Reset mid-clear and mid-ARB: assert Reset at cnt=9, then again with a grant pending -> outputs zero immediately, no write issued, clear restarts at Waddr=0.
REQ-037 Stats with REGWR_ARBITER_STATS_EN: 4 cycles of Req=3'b101 then 2 cycles of Req=3'b001 -> WrCount=6, ConflictCount=4.
REQ-038 Stats saturation: preload near saturation (force) -> WrCount stops at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/regwr_arbiter.sv
// Register-file write arbiter: clears all 2**pw registers after reset, then grants one round-robin write per cycle.
// Optional write/conflict statistics outputs are enabled by defining REGWR_ARBITER_STATS_EN.
module regwr_arbiter #(
  parameter int pw   = 4,
  parameter int NREQ = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*pw-1:0] ReqAddr,
  input  logic [NREQ*8-1:0] ReqData,
  output logic [NREQ-1:0]   Gnt,
  output logic              WriteEn,
  output logic [pw-1:0]     Waddr,
  output logic [7:0]        DataIn,
  output logic              Ready
`ifdef REGWR_ARBITER_STATS_EN
  ,
  output logic [15:0]       WrCount,
  output logic [15:0]       ConflictCount
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic {CLEAR, ARB} state_t;

  state_t            state;
  logic [pw-1:0]     cnt;
  logic [PTRW-1:0]   rr_ptr;
  logic [PTRW-1:0]   winner;
  logic              found;
  logic [pw-1:0]     addr_arr [NREQ];
  logic [7:0]        data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = ReqAddr[g*pw +: pw];
    assign data_arr[g] = ReqData[g*8 +: 8];
  end

  // Search upward from rr_ptr, wrapping at NREQ; the first asserted request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      int unsigned     idx;
      logic [PTRW-1:0] cand;
      idx = 32'(rr_ptr) + i;
      if (idx >= NR) idx = idx - NR;
      cand = PTRW'(idx);
      if (!found && Req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    Gnt = '0;
    if (state == ARB && found) Gnt[winner] = 1'b1;
  end

  assign Ready = (state == ARB);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      rr_ptr  <= '0;
      WriteEn <= 1'b0;
      Waddr   <= '0;
      DataIn  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          WriteEn <= 1'b1;
          Waddr   <= cnt;
          DataIn  <= '0;
          cnt     <= cnt + 1'b1;
          if (cnt == '1) state <= ARB;
        end
        ARB: begin
          if (found) begin
            WriteEn <= 1'b1;
            Waddr   <= addr_arr[winner];
            DataIn  <= data_arr[winner];
            rr_ptr  <= (winner == PTRW'(NREQ-1)) ? '0 : winner + 1'b1;
          end else begin
            WriteEn <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef REGWR_ARBITER_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WrCount       <= '0;
      ConflictCount <= '0;
    end else if (state == ARB) begin
      if (found && WrCount != '1) WrCount <= WrCount + 1'b1;
      if ($countones(Req) > 1 && ConflictCount != '1) ConflictCount <= ConflictCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Scoreboard bench for regwr_arbiter: driver pushes expected writes, negedge monitor pops and compares.
module tb_regwr_arbiter;
  localparam int PW    = 4;
  localparam int N     = 3;
  localparam int NREGS = 1 << PW;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    Req;
  logic [N*PW-1:0] ReqAddr;
  logic [N*8-1:0]  ReqData;
  logic [N-1:0]    Gnt;
  logic            WriteEn;
  logic [PW-1:0]   Waddr;
  logic [7:0]      DataIn;
  logic            Ready;
`ifdef REGWR_ARBITER_STATS_EN
  logic [15:0]     WrCount;
  logic [15:0]     ConflictCount;
`endif

  regwr_arbiter #(.pw(PW), .NREQ(N)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Gnt(Gnt), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .Ready(Ready)
`ifdef REGWR_ARBITER_STATS_EN
    , .WrCount(WrCount), .ConflictCount(ConflictCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [PW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  wr_t           exp_q[$];
  logic [N-1:0]  exp_gnt = '0;
  logic          exp_ready = 1'b0;
  logic [PW-1:0] last_a = '0;
  logic [7:0]    last_d = '0;
  int            clear_left = NREGS;
  int            m_ptr = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must be the oldest expected one.
  always @(negedge Clk) begin
    wr_t w;
    if (mon_en && !Reset) begin
      chk("gnt", 32'(Gnt), 32'(exp_gnt));
      chk("ready", 32'(Ready), 32'(exp_ready));
      if (WriteEn) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(WriteEn), 32'd0);
        else begin
          w = exp_q.pop_front();
          chk("waddr", 32'(Waddr), 32'(w.a));
          chk("wdata", 32'(DataIn), 32'(w.d));
          last_a = w.a;
          last_d = w.d;
        end
      end else begin
        chk("hold_addr", 32'(Waddr), 32'(last_a));
        chk("hold_data", 32'(DataIn), 32'(last_d));
      end
    end
  end

  // Reference model: clear phase counts down, then round-robin over a rotated requester list.
  task automatic setup(input logic [N-1:0] r, input logic [N*PW-1:0] a, input logic [N*8-1:0] d);
    wr_t w;
    bit  got;
    Req = r; ReqAddr = a; ReqData = d;
    exp_gnt = '0;
    if (clear_left > 0) begin
      exp_ready = 1'b0;
      w.a = PW'(NREGS - clear_left);
      w.d = 8'h00;
      exp_q.push_back(w);
      clear_left--;
    end else begin
      exp_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!got && r[idx]) begin
          got = 1'b1;
          exp_gnt[idx] = 1'b1;
          w.a = a[idx*PW +: PW];
          w.d = d[idx*8 +: 8];
          exp_q.push_back(w);
          m_ptr = (idx + 1) % N;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*PW-1:0] a, input logic [N*8-1:0] d);
    setup(r, a, d);
    @(posedge Clk); #1;
  endtask

  task automatic step_chk(input logic [N-1:0] r, input logic [N*PW-1:0] a, input logic [N*8-1:0] d,
                          input logic [N-1:0] g);
    setup(r, a, d);
    #1 chk("dir_gnt", 32'(Gnt), 32'(g));
    @(posedge Clk); #1;
  endtask

  task automatic rstep(input logic [N-1:0] r);
    step(r, (N*PW)'($urandom), (N*8)'($urandom));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    exp_q.delete();
    last_a = '0; last_d = '0;
    m_ptr = 0; clear_left = NREGS;
    exp_gnt = '0; exp_ready = 1'b0;
    #1;
    chk("rst_we", 32'(WriteEn), 32'd0);
    chk("rst_waddr", 32'(Waddr), 32'd0);
    chk("rst_data", 32'(DataIn), 32'd0);
    chk("rst_gnt", 32'(Gnt), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic clear_seq();
    repeat (NREGS) rstep('0);
  endtask

  initial begin
    Reset = 1'b1;
    Req = '0; ReqAddr = '0; ReqData = '0;
    repeat (2) @(posedge Clk);
    #1;
    Req = 3'b111;
    do_reset();
    clear_seq();
    rstep('0);
    rstep('0);

    // Single requester, then pointer sits at 2 so 101 must go to requester 2.
    step_chk(3'b010, 12'h070, 24'h00A500, 3'b010);
    step_chk(3'b101, 12'h321, 24'h112233, 3'b100);
    step_chk(3'b011, 12'h0AB, 24'h445566, 3'b001);
    rstep('0);

    // Reset during the clear sequence at cnt=9.
    do_reset();
    repeat (9) rstep('0);
    do_reset();
    clear_seq();

    // Full load from rr_ptr=0: strict rotation 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] g;
      g = N'(1 << (k % N));
      step_chk(3'b111, (N*PW)'($urandom), (N*8)'($urandom), g);
    end

    // Same destination from everyone: data must land in grant order.
    repeat (4) step(3'b111, {3{4'h5}}, (N*8)'($urandom));
    rstep('0);

    // Reset while a grant is pending.
    setup(3'b110, (N*PW)'($urandom), (N*8)'($urandom));
    #1 chk("pending_gnt", 32'(Gnt), 32'(exp_gnt));
    do_reset();
    clear_seq();

    repeat (300) begin
      if ($urandom_range(3) == 0) rstep('0);
      else rstep(N'($urandom));
    end

`ifdef REGWR_ARBITER_STATS_EN
    do_reset();
    clear_seq();
    repeat (4) rstep(3'b101);
    repeat (2) rstep(3'b001);
    Req = '0;
    #1;
    chk("wrcount", 32'(WrCount), 32'd6);
    chk("conflictcount", 32'(ConflictCount), 32'd4);
    force dut.WrCount = 16'hFFFD;
    #1 release dut.WrCount;
    repeat (4) rstep(3'b001);
    chk("wrcount_sat", 32'(WrCount), 32'h0000FFFF);
`endif

    repeat (3) rstep('0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
